// File: rtl/cla_16bit.sv
// cla_16bit: 16-bit two-level carry-lookahead adder with registered outputs.
//
// The adder has four 4-bit lookahead groups. Each group produces a group
// generate (GG) and a group propagate (GP) term. A second-level lookahead
// unit turns these terms into the carries into each group. Inside a group,
// every carry is one flattened sum-of-products from the group carry-in, so
// no ripple chain runs through the group.
//
// The result is captured on the rising edge of clk whenever in_valid is
// high. When in_valid is low the result registers hold their value and
// out_valid drops. Latency is one clock.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset (clears every output)
//   in_valid  in   1   a/b/cin hold an operation this cycle
//   a         in  16   operand A
//   b         in  16   operand B
//   cin       in   1   carry into bit 0
//   out_valid out  1   s/c/cout hold a result captured on the last edge
//   s         out 16   sum, a+b+cin mod 2^16
//   c         out 16   carry vector, c[i] = carry out of bit i
//   cout      out  1   carry out of bit 15 (same as c[15])
module cla_16bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        out_valid,
  output logic [15:0] s,
  output logic [15:0] c,
  output logic        cout
);

  // Carry out of each bit of one group. Every bit is written as a flattened
  // lookahead equation from the group carry-in.
  function automatic logic [3:0] grp_carry(input logic [3:0] g,
                                           input logic [3:0] p,
                                           input logic       ci);
    logic [3:0] r;
    r[0] = g[0] | (p[0] & ci);
    r[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    r[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    r[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);
    return r;
  endfunction

  // Group generate: the group creates a carry no matter what its carry-in is.
  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Group propagate: the group passes its carry-in through unchanged.
  function automatic logic grp_prop(input logic [3:0] p);
    return &p;
  endfunction

  logic [15:0] g_s;
  logic [15:0] p_s;
  logic [3:0]  gg_s;
  logic [3:0]  gp_s;
  logic [4:0]  gcarry_s;   // gcarry_s[k] = carry into group k, [4] = C16
  logic [15:0] carry_s;    // carry out of each bit
  logic [15:0] cin_vec_s;  // carry into each bit
  logic [15:0] sum_s;

  logic        out_valid_r;
  logic [15:0] s_r;
  logic [15:0] c_r;
  logic        cout_r;

  // Per-bit generate/propagate and the group-level terms.
  always_comb begin
    g_s  = a & b;
    p_s  = a ^ b;
    gg_s = 4'b0000;
    gp_s = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      gg_s[k] = grp_gen(g_s[4*k +: 4], p_s[4*k +: 4]);
      gp_s[k] = grp_prop(p_s[4*k +: 4]);
    end
  end

  // Second-level lookahead: carries into groups 1..3 and out of group 3.
  always_comb begin
    gcarry_s[0] = cin;
    gcarry_s[1] = gg_s[0] | (gp_s[0] & cin);
    gcarry_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & cin);
    gcarry_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[2] & gp_s[1] & gp_s[0] & cin);
    gcarry_s[4] = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & cin);
  end

  // Bit carries inside each group. The top bit of each group comes from the
  // second-level unit, so cout and c[15] are driven by the same C16 term.
  always_comb begin
    logic [3:0] grp_s;
    carry_s = 16'h0000;
    grp_s   = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      grp_s                = grp_carry(g_s[4*k +: 4], p_s[4*k +: 4], gcarry_s[k]);
      carry_s[4*k +: 3]    = grp_s[2:0];
      carry_s[4*k + 3]     = gcarry_s[k + 1];
    end
  end

  // Sum bits: propagate XOR the carry into each bit.
  always_comb begin
    cin_vec_s = {carry_s[14:0], cin};
    sum_s     = p_s ^ cin_vec_s;
  end

  // Result registers: load on a valid operation, otherwise hold. out_valid
  // follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      s_r         <= 16'h0000;
      c_r         <= 16'h0000;
      cout_r      <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        s_r    <= sum_s;
        c_r    <= carry_s;
        cout_r <= gcarry_s[4];
      end else begin
        s_r    <= s_r;
        c_r    <= c_r;
        cout_r <= cout_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign s         = s_r;
  assign c         = c_r;
  assign cout      = cout_r;

endmodule

// File: tb/tb_cla_16bit.sv
// tb_cla_16bit: self-checking bench for cla_16bit. It runs directed cases
// and a randomized regression against an arithmetic reference model.
module tb_cla_16bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic [15:0] s;
  logic [15:0] c;
  logic        cout;

  int checks_r;
  int failures_r;

  // Expected registered state, kept by the model.
  logic        exp_valid;
  logic [15:0] exp_s;
  logic [15:0] exp_c;
  logic        exp_cout;

  cla_16bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .s        (s),
    .c        (c),
    .cout     (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      failures_r++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: c[i] is bit i+1 of the sum of the low i+1 bits of a and b
  // plus cin. The sum is the low 16 bits of the full-width addition.
  function automatic logic [32:0] ref_add(input logic [15:0] ra, input logic [15:0] rb,
                                          input logic rc);
    logic [31:0] mask;
    logic [31:0] part;
    logic [31:0] full;
    logic [15:0] cv;
    cv   = 16'h0000;
    full = 32'(ra) + 32'(rb) + 32'(rc);
    for (int i = 0; i < 16; i++) begin
      mask  = (32'd1 << (i + 1)) - 32'd1;
      part  = (32'(ra) & mask) + (32'(rb) & mask) + 32'(rc);
      cv[i] = part[i + 1];
    end
    return {full[16], cv, full[15:0]};
  endfunction

  task automatic check_outputs(input string tag);
    check_val({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
    check_val({tag, ".s"},     32'(s),         32'(exp_s));
    check_val({tag, ".c"},     32'(c),         32'(exp_c));
    check_val({tag, ".cout"},  32'(cout),      32'(exp_cout));
    check_val({tag, ".c15"},   32'(cout),      32'(c[15]));
  endtask

  // Drive one cycle at the falling edge, let the rising edge capture, then
  // compare 1 time unit after that edge.
  task automatic cycle(input string tag, input logic v, input logic [15:0] ta,
                       input logic [15:0] tb, input logic tc);
    logic [32:0] r;
    @(negedge clk);
    in_valid = v;
    a        = ta;
    b        = tb;
    cin      = tc;
    @(posedge clk);
    r = ref_add(ta, tb, tc);
    exp_valid = v;
    if (v) begin
      exp_s    = r[15:0];
      exp_c    = r[31:16];
      exp_cout = r[32];
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    checks_r   = 0;
    failures_r = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    a          = 16'h0000;
    b          = 16'h0000;
    cin        = 1'b0;
    exp_valid  = 1'b0;
    exp_s      = 16'h0000;
    exp_c      = 16'h0000;
    exp_cout   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 3000 + 2000 + 1, anchored against fixed values as well as the model.
    cycle("t3000", 1'b1, 16'd3000, 16'd2000, 1'b1);
    check_val("t3000.s_const", 32'(s), 32'h1389);
    check_val("t3000.c_const", 32'(c), 32'h0FF0);
    check_val("t3000.cout_const", 32'(cout), 32'h0);
    cycle("t3000_hold", 1'b0, 16'hAAAA, 16'h5555, 1'b1);
    check_val("t3000_hold.s_const", 32'(s), 32'd5001);

    cycle("fullprop", 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    check_val("fullprop.c_const", 32'(c), 32'hFFFF);
    cycle("allones", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    check_val("allones.s_const", 32'(s), 32'hFFFF);
    cycle("msb", 1'b1, 16'h8000, 16'h8000, 1'b0);
    check_val("msb.c_const", 32'(c), 32'h8000);

    // Back-to-back stream.
    cycle("b2b0", 1'b1, 16'h1234, 16'h4321, 1'b0);
    check_val("b2b0.s_const", 32'(s), 32'h5555);
    cycle("b2b1", 1'b1, 16'h00FF, 16'h0001, 1'b0);
    check_val("b2b1.c_const", 32'(c), 32'h00FF);
    cycle("b2b2", 1'b1, 16'h0F0F, 16'hF0F0, 1'b1);
    check_val("b2b2.cout_const", 32'(cout), 32'h1);

    // Asynchronous reset between edges while out_valid=1.
    cycle("pre_rst", 1'b1, 16'h7FFF, 16'h0001, 1'b0);
    @(negedge clk);
    #2;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a         = 16'h1111;
    b         = 16'h2222;
    cin       = 1'b1;
    #1;
    exp_valid = 1'b0;
    exp_s     = 16'h0000;
    exp_c     = 16'h0000;
    exp_cout  = 1'b0;
    check_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("rst_release");
    cycle("post_rst", 1'b1, 16'h1111, 16'h2222, 1'b1);
    check_val("post_rst.s_const", 32'(s), 32'h3334);

    // Random regression with random valid gaps.
    for (int n = 0; n < 10000; n++) begin
      cycle("rand", ($urandom_range(3, 0) != 0) ? 1'b1 : 1'b0,
            16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
